// File: rtl/gpout_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gpout_router
//  Purpose  : Multi-channel debug output router. Each channel picks one of
//             2**SEL_W sources (sel 2 = raw clk, sel 3 = shared divided clk)
//             and conditions it as direct, registered, sticky or stretched.
//  Options  : GPOUT_STRETCH_EN - build per-channel stretch counters; when
//             undefined, mode 11 behaves exactly like mode 01 (registered).
//  Revision : 1.0 - initial release
// ============================================================================
module gpout_router #(
    parameter int NCH         = 6,
    parameter int SEL_W       = 6,
    parameter int DIV_W       = 8,
    parameter int STRETCH_LEN = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2**SEL_W-1:0]    i_src,
    input  logic [NCH*SEL_W-1:0]   i_sel,
    input  logic [NCH*2-1:0]       i_mode,
    input  logic [DIV_W-1:0]       i_div,
    input  logic                   i_clear,
    output logic [NCH-1:0]         o_gpout
);

    localparam logic [1:0]       c_MODE_DIRECT  = 2'b00;
    localparam logic [1:0]       c_MODE_REG     = 2'b01;
    localparam logic [1:0]       c_MODE_STICKY  = 2'b10;
    localparam logic [1:0]       c_MODE_STRETCH = 2'b11;
    localparam logic [SEL_W-1:0] c_SEL_CLK      = SEL_W'(2);
    localparam logic [SEL_W-1:0] c_SEL_DIV      = SEL_W'(3);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             div_clk_q, div_clk_d;

    // Shared divider: wrap as soon as the count reaches or passes the terminal
    // value, so lowering i_div never causes a long count-out.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        div_clk_d = div_clk_q;
        if (div_cnt_q >= i_div) begin
            div_cnt_d = '0;
            div_clk_d = ~div_clk_q;
        end
    end

    // Divider state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            div_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            div_clk_q <= div_clk_d;
        end
    end

    genvar n;
    generate
        for (n = 0; n < NCH; n++) begin : g_ch
            logic [SEL_W-1:0] w_sel;
            logic [1:0]       w_mode;
            logic             w_src_state;
            logic             w_direct;
            logic             w_cond;
            logic             w_guard;
            logic [SEL_W-1:0] sel_q;
            logic             hold_q, hold_d;

            assign w_sel   = i_sel[n*SEL_W +: SEL_W];
            assign w_mode  = i_mode[n*2 +: 2];
            // A select change or a global clear forces all state to zero.
            assign w_guard = i_clear || (w_sel != sel_q);

            // Source seen by the direct path (raw clk included) and by the
            // state path (raw clk excluded: that channel is always direct).
            always_comb begin
                w_direct    = i_src[w_sel];
                w_src_state = i_src[w_sel];
                if (w_sel == c_SEL_CLK) begin
                    w_direct    = clk;
                    w_src_state = 1'b0;
                end else if (w_sel == c_SEL_DIV) begin
                    w_direct    = div_clk_q;
                    w_src_state = div_clk_q;
                end
            end

            // Registered/sticky state update; direct and stretch modes hold.
            always_comb begin
                case (w_mode)
                    c_MODE_REG:     hold_d = w_src_state;
                    c_MODE_STICKY:  hold_d = hold_q | w_src_state;
`ifndef GPOUT_STRETCH_EN
                    c_MODE_STRETCH: hold_d = w_src_state;
`endif
                    default:        hold_d = hold_q;
                endcase
                if (w_guard) hold_d = 1'b0;
            end

            // Per-channel state registers
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sel_q  <= '0;
                    hold_q <= 1'b0;
                end else begin
                    sel_q  <= w_sel;
                    hold_q <= hold_d;
                end
            end

`ifdef GPOUT_STRETCH_EN
            localparam int c_CNT_W = $clog2(STRETCH_LEN + 1);
            logic [c_CNT_W-1:0] cnt_q, cnt_d;

            // Stretch counter: reload on a sampled source, otherwise count down.
            always_comb begin
                cnt_d = cnt_q;
                if (w_mode == c_MODE_STRETCH) begin
                    if (w_src_state)
                        cnt_d = c_CNT_W'(STRETCH_LEN);
                    else if (cnt_q != '0)
                        cnt_d = cnt_q - c_CNT_W'(1);
                end
                if (w_guard) cnt_d = '0;
            end

            // Stretch counter register
            always_ff @(posedge clk or posedge reset) begin
                if (reset) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end

            // Conditioned value: stretch shows a live count, others show state.
            always_comb begin
                w_cond = hold_q;
                if (w_mode == c_MODE_STRETCH) w_cond = (cnt_q != '0);
            end
`else
            assign w_cond = hold_q;
`endif

            assign o_gpout[n] = ((w_mode == c_MODE_DIRECT) || (w_sel == c_SEL_CLK))
                                ? w_direct : w_cond;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gpout_router.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gpout_router
//  Purpose  : Directed self-checking bench for gpout_router, plus a random
//             multi-channel run against a small reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpout_router;

    localparam int NCH         = 6;
    localparam int SEL_W       = 6;
    localparam int DIV_W       = 8;
    localparam int STRETCH_LEN = 15;
    localparam int NSRC        = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NSRC-1:0]      i_src;
    logic [NCH*SEL_W-1:0] i_sel;
    logic [NCH*2-1:0]     i_mode;
    logic [DIV_W-1:0]     i_div;
    logic                 i_clear;
    logic [NCH-1:0]       o_gpout;

    int total = 0;
    int bad   = 0;

    gpout_router #(
        .NCH(NCH), .SEL_W(SEL_W), .DIV_W(DIV_W), .STRETCH_LEN(STRETCH_LEN)
    ) dut (
        .clk(clk), .reset(reset), .i_src(i_src), .i_sel(i_sel),
        .i_mode(i_mode), .i_div(i_div), .i_clear(i_clear), .o_gpout(o_gpout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int n, input int sel, input logic [1:0] mode);
        i_sel[n*SEL_W +: SEL_W] = SEL_W'(sel);
        i_mode[n*2 +: 2]        = mode;
    endtask

    task automatic test_reset();
        i_src = '0; i_sel = '0; i_mode = '0; i_div = 8'd2; i_clear = 1'b0;
        set_ch(0, 0, 2'b01);
        set_ch(1, 0, 2'b10);
        set_ch(2, 0, 2'b11);
        set_ch(3, 5, 2'b00);
        i_src[5] = 1'b1;
        reset = 1'b1;
        #2;
        total++;
        if (o_gpout[2:0] !== 3'b000) begin
            bad++; $display("FAIL reset_cond: got %b want 000", o_gpout[2:0]);
        end
        total++;
        if (o_gpout[3] !== 1'b1) begin
            bad++; $display("FAIL reset_direct: got %b want 1", o_gpout[3]);
        end
        i_src[0] = 1'b1;
        tick();
        total++;
        if (o_gpout[2:0] !== 3'b000) begin
            bad++; $display("FAIL reset_held: got %b want 000", o_gpout[2:0]);
        end
        reset = 1'b0;
        tick();
        total++;
        if (o_gpout[2:0] !== 3'b111) begin
            bad++; $display("FAIL reset_first_load: got %b want 111", o_gpout[2:0]);
        end
    endtask

    task automatic test_divider();
        logic exp_d, exp_r;
        reset = 1'b1;
        i_src = '0; i_sel = '0; i_mode = '0; i_div = 8'd2;
        set_ch(0, 3, 2'b01);
        set_ch(1, 3, 2'b00);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp_d = ((k / 3) % 2) == 1;
            exp_r = (((k - 1) / 3) % 2) == 1;
            total++;
            if (o_gpout[1] !== exp_d) begin
                bad++; $display("FAIL div2_direct k=%0d: got %b want %b", k, o_gpout[1], exp_d);
            end
            total++;
            if (o_gpout[0] !== exp_r) begin
                bad++; $display("FAIL div2_reg k=%0d: got %b want %b", k, o_gpout[0], exp_r);
            end
        end
        i_div = 8'd0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            exp_d = (j % 2) == 1;
            exp_r = ((j - 1) % 2) == 1;
            total++;
            if (o_gpout[1] !== exp_d) begin
                bad++; $display("FAIL div0_direct j=%0d: got %b want %b", j, o_gpout[1], exp_d);
            end
            total++;
            if (o_gpout[0] !== exp_r) begin
                bad++; $display("FAIL div0_reg j=%0d: got %b want %b", j, o_gpout[0], exp_r);
            end
        end
    endtask

    task automatic test_direct_reg();
        i_src = '0;
        set_ch(0, 10, 2'b00);
        set_ch(2, 10, 2'b01);
        tick(); tick();
        total++;
        if ({o_gpout[2], o_gpout[0]} !== 2'b00) begin
            bad++; $display("FAIL dr_idle: got %b want 00", {o_gpout[2], o_gpout[0]});
        end
        i_src[10] = 1'b1;
        #1;
        total++;
        if ({o_gpout[2], o_gpout[0]} !== 2'b01) begin
            bad++; $display("FAIL dr_same_cycle: got %b want 01", {o_gpout[2], o_gpout[0]});
        end
        tick();
        total++;
        if ({o_gpout[2], o_gpout[0]} !== 2'b11) begin
            bad++; $display("FAIL dr_next_cycle: got %b want 11", {o_gpout[2], o_gpout[0]});
        end
        i_src[11] = 1'b1;
        set_ch(2, 11, 2'b01);
        tick();
        total++;
        if (o_gpout[2] !== 1'b0) begin
            bad++; $display("FAIL reg_sel_guard: got %b want 0", o_gpout[2]);
        end
        tick();
        total++;
        if (o_gpout[2] !== 1'b1) begin
            bad++; $display("FAIL reg_after_guard: got %b want 1", o_gpout[2]);
        end
        set_ch(2, 11, 2'b10);
        i_src[11] = 1'b0;
        tick();
        total++;
        if (o_gpout[2] !== 1'b1) begin
            bad++; $display("FAIL mode_change_keeps: got %b want 1", o_gpout[2]);
        end
        i_src = '0;
    endtask

    task automatic test_sticky();
        i_src = '0; i_clear = 1'b0;
        set_ch(3, 40, 2'b10);
        tick(); tick();
        total++;
        if (o_gpout[3] !== 1'b0) begin
            bad++; $display("FAIL sticky_idle: got %b want 0", o_gpout[3]);
        end
        i_src[40] = 1'b1; tick(); i_src[40] = 1'b0;
        total++;
        if (o_gpout[3] !== 1'b1) begin
            bad++; $display("FAIL sticky_set: got %b want 1", o_gpout[3]);
        end
        for (int k = 0; k < 100; k++) begin
            tick();
            total++;
            if (o_gpout[3] !== 1'b1) begin
                bad++; $display("FAIL sticky_hold k=%0d: got %b want 1", k, o_gpout[3]);
            end
        end
        i_clear = 1'b1; tick(); i_clear = 1'b0;
        total++;
        if (o_gpout[3] !== 1'b0) begin
            bad++; $display("FAIL sticky_clear: got %b want 0", o_gpout[3]);
        end
        i_src[40] = 1'b1; tick(); i_src[40] = 1'b0;
        total++;
        if (o_gpout[3] !== 1'b1) begin
            bad++; $display("FAIL sticky_reset_again: got %b want 1", o_gpout[3]);
        end
        i_src[41] = 1'b1;
        set_ch(3, 41, 2'b10);
        tick();
        total++;
        if (o_gpout[3] !== 1'b0) begin
            bad++; $display("FAIL sticky_selchg_wins: got %b want 0", o_gpout[3]);
        end
        tick();
        total++;
        if (o_gpout[3] !== 1'b1) begin
            bad++; $display("FAIL sticky_new_src: got %b want 1", o_gpout[3]);
        end
        i_clear = 1'b1; tick();
        total++;
        if (o_gpout[3] !== 1'b0) begin
            bad++; $display("FAIL sticky_clear_prio: got %b want 0", o_gpout[3]);
        end
        i_clear = 1'b0; i_src[41] = 1'b0;
        i_src = '0;
    endtask

    task automatic test_stretch();
        logic exp;
        i_src = '0;
        set_ch(4, 20, 2'b11);
        tick(); tick();
        total++;
        if (o_gpout[4] !== 1'b0) begin
            bad++; $display("FAIL stretch_idle: got %b want 0", o_gpout[4]);
        end
        for (int r = 0; r < 2; r++) begin
            for (int k = 1; k <= 30; k++) begin
                i_src[20] = (k == 1) || (r == 1 && k == 11);
                tick();
`ifdef GPOUT_STRETCH_EN
                exp = (r == 0) ? (k <= 15) : (k <= 25);
`else
                exp = (k == 1) || (r == 1 && k == 11);
`endif
                total++;
                if (o_gpout[4] !== exp) begin
                    bad++; $display("FAIL stretch r=%0d k=%0d: got %b want %b", r, k, o_gpout[4], exp);
                end
            end
        end
        i_src = '0;
    endtask

    task automatic test_reset_mid();
        i_src = '0; i_div = 8'd0;
        set_ch(1, 3, 2'b00);
        set_ch(3, 40, 2'b10);
        set_ch(4, 20, 2'b11);
        set_ch(5, 2, 2'b01);
        tick(); tick();
        i_src[40] = 1'b1; tick(); i_src[40] = 1'b0;
        i_src[20] = 1'b1; tick(); i_src[20] = 1'b0;
        tick();
        for (int w = 0; w < 4 && o_gpout[1] !== 1'b1; w++) tick();
        total++;
        if (o_gpout[1] !== 1'b1) begin
            bad++; $display("FAIL mid_divclk_high_timeout: got %b want 1", o_gpout[1]);
        end
        total++;
        if (o_gpout[3] !== 1'b1) begin
            bad++; $display("FAIL mid_sticky_pre: got %b want 1", o_gpout[3]);
        end
`ifdef GPOUT_STRETCH_EN
        total++;
        if (o_gpout[4] !== 1'b1) begin
            bad++; $display("FAIL mid_stretch_pre: got %b want 1", o_gpout[4]);
        end
`endif
        #1;
        reset = 1'b1;
        #1;
        total++;
        if (o_gpout[4:1] !== 4'b0000) begin
            bad++; $display("FAIL mid_reset_async: got %b want 0000", o_gpout[4:1]);
        end
        total++;
        if (o_gpout[5] !== 1'b1) begin
            bad++; $display("FAIL mid_clk_high: got %b want 1", o_gpout[5]);
        end
        @(negedge clk); #1;
        total++;
        if (o_gpout[5] !== 1'b0) begin
            bad++; $display("FAIL mid_clk_low: got %b want 0", o_gpout[5]);
        end
        tick();
        total++;
        if (o_gpout[4:1] !== 4'b0000) begin
            bad++; $display("FAIL mid_reset_held: got %b want 0000", o_gpout[4:1]);
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic       mq [NCH];
        int         mc [NCH];
        int         ms [NCH];
        logic       nq [NCH];
        int         nc [NCH];
        int         mdiv, sel, mode;
        logic       mdclk, s;
        logic [NCH-1:0] exp;

        reset = 1'b1; i_clear = 1'b0; i_div = 8'd1; i_src = '0;
        for (int n = 0; n < NCH; n++) set_ch(n, n * 9 + 1, 2'(n % 4));
        tick();
        reset = 1'b0;
        for (int n = 0; n < NCH; n++) begin mq[n] = 1'b0; mc[n] = 0; ms[n] = 0; end
        mdiv = 0; mdclk = 1'b0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            i_src   = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            i_clear = ($urandom_range(0, 31) == 0);
            for (int n = 0; n < NCH; n++) begin
                if ($urandom_range(0, 15) == 0)
                    set_ch(n, $urandom_range(0, 63), 2'($urandom_range(0, 3)));
                else if ($urandom_range(0, 15) == 0)
                    i_mode[n*2 +: 2] = 2'($urandom_range(0, 3));
            end
            for (int n = 0; n < NCH; n++) begin
                sel = int'(i_sel[n*SEL_W +: SEL_W]);
                mode = int'(i_mode[n*2 +: 2]);
                s = (sel == 2) ? 1'b0 : (sel == 3) ? mdclk : i_src[sel];
                nq[n] = mq[n];
                nc[n] = mc[n];
                if (mode == 1) nq[n] = s;
                else if (mode == 2) nq[n] = mq[n] | s;
                else if (mode == 3) begin
`ifdef GPOUT_STRETCH_EN
                    if (s) nc[n] = STRETCH_LEN;
                    else if (mc[n] > 0) nc[n] = mc[n] - 1;
`else
                    nq[n] = s;
`endif
                end
                if (i_clear || sel != ms[n]) begin nq[n] = 1'b0; nc[n] = 0; end
            end
            tick();
            if (mdiv >= int'(i_div)) begin mdiv = 0; mdclk = ~mdclk; end
            else mdiv = mdiv + 1;
            for (int n = 0; n < NCH; n++) begin
                sel = int'(i_sel[n*SEL_W +: SEL_W]);
                mode = int'(i_mode[n*2 +: 2]);
                mq[n] = nq[n]; mc[n] = nc[n]; ms[n] = sel;
                if (mode == 0 || sel == 2)
                    exp[n] = (sel == 2) ? 1'b1 : (sel == 3) ? mdclk : i_src[sel];
`ifdef GPOUT_STRETCH_EN
                else if (mode == 3) exp[n] = (mc[n] != 0);
`endif
                else exp[n] = mq[n];
            end
            total++;
            if (o_gpout !== exp) begin
                bad++; $display("FAIL random cyc=%0d: got %b want %b", cyc, o_gpout, exp);
            end
        end
        i_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_divider();
        test_direct_reg();
        test_sticky();
        test_stretch();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
